// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with KMP fallback, overlap mode and saturating match counter.
// seq_detected is combinational (zero latency); seq_detected_q and match_count follow one cycle later.
module seq_detector_param #(
  parameter int                     PATTERN_LEN = 5,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 5'b10101,
  parameter int                     COUNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           din,
  input  logic                           din_valid,
  input  logic                           overlap,
  input  logic                           count_clr,
  output logic                           seq_detected,
  output logic                           seq_detected_q,
  output logic [$clog2(PATTERN_LEN+1)-1:0] match_len,
  output logic [COUNT_W-1:0]             match_count
);

  localparam int SW = $clog2(PATTERN_LEN+1);

  generate
    if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
      $error("seq_detector_param: PATTERN_LEN must be within 2..16");
    end
  endgenerate

  // Bit i of the pattern in arrival order (i = 0 is received first).
  function automatic logic pbit(input int i);
    return PATTERN[PATTERN_LEN-1-i];
  endfunction

  // Mismatch target per state: longest pattern prefix that ends the matched bits plus the complement of E.
  function automatic logic [16*5-1:0] calc_fail();
    logic [16*5-1:0] tbl;
    int              best;
    int              j;
    logic            ok;
    logic            tbit;
    tbl = '0;
    for (int s = 0; s < PATTERN_LEN; s++) begin
      best = 0;
      for (int k = 1; k <= s; k++) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          j    = s + 1 - k + i;
          tbit = (j == s) ? ~pbit(s) : pbit(j);
          if (tbit != pbit(i)) ok = 1'b0;
        end
        if (ok) best = k;
      end
      tbl[s*5 +: 5] = 5'(best);
    end
    return tbl;
  endfunction

  function automatic int calc_border();
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < PATTERN_LEN; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pbit(i) != pbit(PATTERN_LEN - k + i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  localparam logic [16*5-1:0] FAIL_TBL = calc_fail();
  localparam logic [SW-1:0]   BORDER_S = SW'(calc_border());
  localparam logic [SW-1:0]   LAST_S   = SW'(PATTERN_LEN-1);

  logic [SW-1:0]      s_q, s_d;
  logic               det_q;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               e_bit;
  logic               hit;
  logic               last;
  logic               det;

  assign e_bit = PATTERN[LAST_S - s_q];
  assign hit   = (din == e_bit);
  assign last  = (s_q == LAST_S);
  assign det   = din_valid & ~reset & last & hit;

  always_comb begin
    s_d = s_q;
    if (din_valid) begin
      if (hit) begin
        if (last) s_d = overlap ? BORDER_S : '0;
        else      s_d = s_q + 1'b1;
      end else begin
        s_d = FAIL_TBL[int'(s_q)*5 +: SW];
      end
    end
  end

  // A clear coinciding with a detection still records that detection.
  always_comb begin
    cnt_d = cnt_q;
    if (det) begin
      if (count_clr)       cnt_d = COUNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (count_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= '0;
      det_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      det_q <= det;
      cnt_q <= cnt_d;
    end
  end

  assign seq_detected   = det;
  assign seq_detected_q = det_q;
  assign match_len      = s_q;
  assign match_count    = cnt_q;

endmodule
